// File: rtl/haar_integral_builder_if.sv
// Pixel-stream / integral-buffer handshake between the window feeder, this
// builder, and the HAAR comparison stage.
interface haar_integral_builder_if #(
    parameter int WIN_W = 20,
    parameter int WIN_H = 20,
    parameter int PIX_W = 8,
    parameter int SUM_W = 32
);
    logic [PIX_W-1:0]                   pix_data;
    logic                               pix_valid;
    logic                               pix_sof;
    logic                               pix_ready;
    logic [WIN_W*WIN_H-1:0][SUM_W-1:0]  integral_buffer;
    logic                               START;
    logic                               FACE_ACK;

    modport master (
        output pix_data, pix_valid, pix_sof, FACE_ACK,
        input  pix_ready, integral_buffer, START
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, FACE_ACK,
        output pix_ready, integral_buffer, START
    );
endinterface

// File: rtl/haar_integral_builder.sv
// Builds the integral image of one WIN_W x WIN_H window from a raster pixel
// stream and holds it frozen with START until the consumer acknowledges.
module haar_integral_builder #(
    parameter int WIN_W = 20,
    parameter int WIN_H = 20,
    parameter int PIX_W = 8,
    parameter int SUM_W = 32
) (
    input  logic Clk,
    input  logic Reset,
    haar_integral_builder_if.slave bus
);
    localparam int DEPTH = WIN_W * WIN_H;
    localparam int XW    = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int YW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_next;
    logic [XW-1:0]    x, x_next, cx;
    logic [YW-1:0]    y, y_next, cy;
    logic [SUM_W-1:0] row_acc, row_next, above, ii;
    logic [SUM_W-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx;
    logic             ready, xfer, take, last;

    always_comb begin
        xfer       = bus.pix_valid && ready;
        // IDLE only reacts to a start-of-frame pixel; everything else is dropped
        take       = xfer && (state == ACCUM || (state == IDLE && bus.pix_sof));
        cx         = bus.pix_sof ? '0 : x;
        cy         = bus.pix_sof ? '0 : y;
        wr_idx     = IW'(cy) * IW'(WIN_W) + IW'(cx);
        row_next   = ((cx == '0) ? '0 : row_acc) + SUM_W'(bus.pix_data);
        above      = (cy == '0) ? '0 : mem[wr_idx - IW'(WIN_W)];
        ii         = row_next + above;
        last       = (cx == XW'(WIN_W-1)) && (cy == YW'(WIN_H-1));
        state_next = state;
        x_next     = x;
        y_next     = y;
        case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    if (last) begin
                        state_next = DONE;
                        x_next     = '0;
                        y_next     = '0;
                    end else begin
                        state_next = ACCUM;
                        if (cx == XW'(WIN_W-1)) begin
                            x_next = '0;
                            y_next = cy + YW'(1);
                        end else begin
                            x_next = cx + XW'(1);
                            y_next = cy;
                        end
                    end
                end
            end
            DONE:    if (bus.FACE_ACK) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready is registered from the next state so pix_valid never reaches it combinationally
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            row_acc <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            x       <= x_next;
            y       <= y_next;
            ready   <= (state_next != DONE);
            if (take) row_acc <= row_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (take) begin
            mem[wr_idx] <= ii;
        end
    end

    assign bus.pix_ready = ready;
    assign bus.START     = (state == DONE);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) bus.integral_buffer[i] = mem[i];
    end
endmodule

// File: tb/tb_haar_integral_builder.sv
// Bench for haar_integral_builder: table vectors, randomized gap stream
// against a direct-summation integral model, and reset/restart sequences.
module tb_haar_integral_builder;
    localparam int WIN_W = 20;
    localparam int WIN_H = 20;
    localparam int PIX_W = 8;
    localparam int SUM_W = 32;
    localparam int DEPTH = WIN_W * WIN_H;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    haar_integral_builder_if #(.WIN_W(WIN_W), .WIN_H(WIN_H), .PIX_W(PIX_W), .SUM_W(SUM_W)) bus ();

    haar_integral_builder #(.WIN_W(WIN_W), .WIN_H(WIN_H), .PIX_W(PIX_W), .SUM_W(SUM_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pix_arr [DEPTH];
    logic [SUM_W-1:0] ref_buf [DEPTH];
    bit start_early;

    typedef struct {
        int         pix;
        int         idx;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // integral image by direct summation over the window
    task automatic build_ref();
        for (int y = 0; y < WIN_H; y++)
            for (int x = 0; x < WIN_W; x++) begin
                longint s = 0;
                for (int j = 0; j <= y; j++)
                    for (int i = 0; i <= x; i++) s += pix_arr[j*WIN_W+i];
                ref_buf[y*WIN_W+x] = SUM_W'(s);
            end
    endtask

    task automatic zero_ref();
        for (int i = 0; i < DEPTH; i++) ref_buf[i] = '0;
    endtask

    function automatic int first_buf_diff();
        for (int i = 0; i < DEPTH; i++)
            if (bus.integral_buffer[i] !== ref_buf[i]) return i;
        return -1;
    endfunction

    task automatic check_buf(input string name);
        int d;
        d = first_buf_diff();
        n_cmp++;
        if (d >= 0) begin
            n_bad++;
            $display("FAIL %s: entry %0d got %0d expected %0d", name, d,
                     bus.integral_buffer[d], ref_buf[d]);
        end
    endtask

    task automatic send(input int p, input bit sof);
        int n = 0;
        bus.pix_data  = PIX_W'(p);
        bus.pix_sof   = sof;
        bus.pix_valid = 1'b1;
        while (!bus.pix_ready && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge Clk); #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic idle_cycle(input bit ack_noise);
        bus.pix_valid = 1'b0;
        bus.FACE_ACK  = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge Clk); #1;
        bus.FACE_ACK  = 1'b0;
    endtask

    // sends pix_arr as one window, sof on the first pixel
    task automatic send_frame(input int gap_pct, input bit ack_noise);
        start_early = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle(ack_noise);
            send(pix_arr[k], k == 0);
            if (k < DEPTH-1 && bus.START) start_early = 1'b1;
        end
        chk("start_early", start_early, 0);
        chk("start_rise", bus.START, 1);
        chk("ready_in_done", bus.pix_ready, 0);
    endtask

    task automatic ack();
        bus.FACE_ACK = 1'b1;
        @(posedge Clk); #1;
        bus.FACE_ACK = 1'b0;
        chk("ack_start", bus.START, 0);
        chk("ack_ready", bus.pix_ready, 1);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < DEPTH; k++) pix_arr[k] = v;
    endtask

    initial begin
        int bad;
        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.FACE_ACK  = 1'b0;
        Reset         = 1'b1;

        tbl[0] = '{1, 0, 1};
        tbl[1] = '{1, 19, 20};
        tbl[2] = '{1, 20, 2};
        tbl[3] = '{1, 399, 400};
        tbl[4] = '{1, 210, 121};
        tbl[5] = '{255, 399, 102000};
        tbl[6] = '{255, 19, 5100};
        tbl[7] = '{255, 380, 5100};
        tbl[8] = '{255, 0, 255};

        // reset state
        repeat (2) @(posedge Clk);
        #1;
        zero_ref();
        chk("rst_ready", bus.pix_ready, 0);
        chk("rst_start", bus.START, 0);
        check_buf("rst_buf");
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("rst_ready_after", bus.pix_ready, 1);

        // uniform frames, spot entries from the table
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || tbl[i].pix != tbl[i-1].pix) begin
                if (i != 0) ack();
                fill(tbl[i].pix);
                send_frame(0, 1'b0);
            end
            chk($sformatf("tbl%0d_entry%0d", i, tbl[i].idx),
                bus.integral_buffer[tbl[i].idx], tbl[i].exp);
        end

        // hold in DONE without ack: frozen buffer, START high, not ready
        fill(255);
        build_ref();
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            bus.pix_data  = 8'h55;
            bus.pix_valid = 1'b1;
            bus.pix_sof   = c[0];
            @(posedge Clk); #1;
            if (!bus.START || bus.pix_ready || first_buf_diff() >= 0) bad++;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        chk("hold_50_bad_cycles", bad, 0);
        check_buf("hold_buf");
        ack();

        // x+y ramp with random valid gaps and stray FACE_ACKs
        for (int k = 0; k < DEPTH; k++) pix_arr[k] = (k % WIN_W) + (k / WIN_W);
        build_ref();
        send_frame(30, 1'b1);
        check_buf("ramp_gaps_buf");
        ack();

        // restart with sof at pixel 137 of a partial window
        start_early = 1'b0;
        for (int k = 0; k < 137; k++) begin
            send($urandom_range(0, 255), k == 0);
            if (bus.START) start_early = 1'b1;
        end
        chk("partial_no_start", start_early, 0);
        fill(1);
        build_ref();
        send_frame(0, 1'b0);
        check_buf("restart_buf");
        ack();

        // reset mid-frame with a pixel in flight
        for (int k = 0; k < 200; k++) send(k % 256, k == 0);
        bus.pix_data  = 8'd9;
        bus.pix_valid = 1'b1;
        Reset         = 1'b1;
        @(posedge Clk); #1;
        bus.pix_valid = 1'b0;
        zero_ref();
        chk("midrst_start", bus.START, 0);
        chk("midrst_ready", bus.pix_ready, 0);
        check_buf("midrst_buf");
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("midrst_ready_after", bus.pix_ready, 1);
        for (int k = 0; k < 5; k++) send(7, 1'b0);
        check_buf("midrst_nosof_buf");
        chk("midrst_nosof_start", bus.START, 0);

        // reset while START is held
        fill(1);
        send_frame(0, 1'b0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        zero_ref();
        chk("donerst_start", bus.START, 0);
        check_buf("donerst_buf");
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("donerst_ready_after", bus.pix_ready, 1);
        for (int k = 0; k < 3; k++) send(200, 1'b0);
        check_buf("donerst_nosof_buf");

        // random frame after reset proves IDLE resumes on sof
        for (int k = 0; k < DEPTH; k++) pix_arr[k] = $urandom_range(0, 255);
        build_ref();
        send_frame(10, 1'b0);
        check_buf("random_buf");
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
